decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 The block SHALL have port instr, input, 32 bits, the instruction from the IF/ID register.
REQ-004 The block SHALL have port pcIn, input, 32 bits, PC+4 from the IF/ID register.
REQ-005 The block SHALL have ports wbRegWrite (1), wbWriteReg (5) and wbWriteData (32), all inputs, forming the writeback port.
REQ-006 The block SHALL have ports exMemRead (1) and exRt (5), both inputs, the load indication and rt field of the instruction now in ID/EX.
REQ-007 The block SHALL have port flush, input, 1 bit, which squashes the current decode (branch taken).
REQ-008 The block SHALL have outputs pc (32), reg1 (32), reg2 (32), offset (32), rt (5) and rd (5), which feed the ID/EX register.
REQ-009 The block SHALL have control outputs RegDest, ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite and MemtoReg, which feed the ID/EX register.
REQ-010 The block SHALL have outputs pcWrite, ifidWrite and stall, each 1 bit, as hazard controls to the fetch side.

Function
REQ-011 The block SHALL hold a 32x32 register file; register 0 reads 0 and ignores writes.
REQ-012 Writes SHALL occur on the rising clock edge when wbRegWrite=1 and wbWriteReg!=0; writes while reset=1 are discarded.
REQ-013 Reads SHALL be combinational: reg1=R[instr[25:21]] and reg2=R[instr[20:16]].
REQ-014 Write-first bypass SHALL apply: if wbRegWrite=1, wbWriteReg!=0 and wbWriteReg matches a read index, that output SHALL equal wbWriteData in the same cycle.
REQ-015 Pass-through outputs SHALL be driven as pc=pcIn, rt=instr[20:16], rd=instr[15:11] and offset={16{instr[15]},instr[15:0]}.
REQ-016 The decoder SHALL map opcode 0x00 (R-type) to RegDest=1, RegWrite=1, ALUOp=10, with all other controls 0.
REQ-017 The decoder SHALL map opcode 0x23 (lw) to ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1, ALUOp=00, with all other controls 0.
REQ-018 The decoder SHALL map opcode 0x2B (sw) to ALUSrc=1, MemWrite=1, ALUOp=00, with all other controls 0.
REQ-019 The decoder SHALL map opcode 0x04 (beq) to Branch=1, ALUOp=01, with all other controls 0.
REQ-020 The decoder SHALL map opcode 0x08 (addi) to ALUSrc=1, RegWrite=1, ALUOp=00, with all other controls 0.
REQ-021 Any other opcode SHALL produce all controls 0 (bubble).
REQ-022 stall SHALL be 1 iff exMemRead=1, exRt!=0 and exRt equals instr[25:21] or instr[20:16]; this is a load-use hazard.
REQ-023 While stall=1, pcWrite=0, ifidWrite=0 and all control outputs SHALL be 0, so that a bubble enters ID/EX.
REQ-024 While flush=1, all control outputs SHALL be 0, and pcWrite and ifidWrite SHALL follow the stall rule.
REQ-025 When stall and flush are asserted simultaneously, controls SHALL be 0, and stall SHALL govern pcWrite and ifidWrite.
REQ-026 With no stall, pcWrite SHALL be 1 and ifidWrite SHALL be 1.
REQ-027 Data outputs (pc, reg1, reg2, offset, rt, rd) SHALL NOT be gated by stall or flush.

Reset
REQ-028 On a rising edge with reset=1, all 32 registers SHALL clear to 0.
REQ-029 While reset=1, all control outputs and stall SHALL be 0, and pcWrite and ifidWrite SHALL be 1.
REQ-030 Reset asserted in the same cycle as a writeback SHALL discard the write; after reset, every register SHALL read 0.

Verification
REQ-031 The bench SHALL cover writeback of R5=0x12345678, then instr=0x00A53020 (add $6,$5,$5), which SHALL give reg1=reg2=0x12345678, RegDest=1, RegWrite=1, ALUOp=10.
REQ-032 The bench SHALL cover the same-cycle bypass: wbRegWrite=1, wbWriteReg=9, wbWriteData=0xDEADBEEF and instr reading rs=9, which SHALL give reg1=0xDEADBEEF in that cycle.
REQ-033 The bench SHALL cover a load-use hazard: exMemRead=1, exRt=8 and instr=0x01095020 (rs=8), which SHALL give stall=1, pcWrite=0, ifidWrite=0 and all controls 0, while reg1 still equals R8.
REQ-034 The bench SHALL cover sign extension: lw instr=0x8C22FFFC, which SHALL give offset=0xFFFFFFFC, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1.
REQ-035 The bench SHALL cover register 0: a write of 0xFFFFFFFF to R0, then a read of rs=0, which SHALL give reg1=0; exMemRead=1 with exRt=0 SHALL give stall=0.
REQ-036 The bench SHALL cover reset mid-operation: R3 holds 7, then reset pulses for 1 cycle together with a writeback to R4, after which reads of R3 and R4 SHALL both return 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID inputs, writeback and hazard inputs, and ID/EX outputs of the decode stage
interface decode_stage_if;
    logic [31:0] instr;
    logic [31:0] pcIn;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] offset;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        RegDest;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemtoReg;
    logic        pcWrite;
    logic        ifidWrite;
    logic        stall;

    modport master (
        output instr, pcIn, wbRegWrite, wbWriteReg, wbWriteData, exMemRead, exRt, flush,
        input  pc, reg1, reg2, offset, rt, rd,
        input  RegDest, ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg,
        input  pcWrite, ifidWrite, stall
    );

    modport slave (
        input  instr, pcIn, wbRegWrite, wbWriteReg, wbWriteData, exMemRead, exRt, flush,
        output pc, reg1, reg2, offset, rt, rd,
        output RegDest, ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg,
        output pcWrite, ifidWrite, stall
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file, main decoder and load-use hazard detection for the ID stage
module decode_stage (
    input logic           clock,
    input logic           reset,
    decode_stage_if.slave bus
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic        wb_en;
    logic        hazard;
    logic [8:0]  ctrl_raw;
    logic [8:0]  ctrl_out;

    assign rs_idx = bus.instr[25:21];
    assign rt_idx = bus.instr[20:16];
    assign wb_en  = bus.wbRegWrite && (bus.wbWriteReg != 5'd0);

    // next register file contents: apply the writeback, R0 is never targeted
    always_comb begin
        regs_d = regs_q;
        if (wb_en) regs_d[bus.wbWriteReg] = bus.wbWriteData;
    end

    // register file state; reset clears every entry and drops a coincident write
    always_ff @(posedge clock) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    // write-first reads so a writeback is visible to the instruction decoding now
    always_comb begin
        bus.reg1 = (wb_en && bus.wbWriteReg == rs_idx) ? bus.wbWriteData : regs_q[rs_idx];
        bus.reg2 = (wb_en && bus.wbWriteReg == rt_idx) ? bus.wbWriteData : regs_q[rt_idx];
    end

    // main decoder: {RegDest, ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
    always_comb begin
        ctrl_raw = 9'b0;
        case (bus.instr[31:26])
            6'h00:   ctrl_raw = 9'b1_10_0_0_0_0_1_0;
            6'h23:   ctrl_raw = 9'b0_00_1_0_1_0_1_1;
            6'h2B:   ctrl_raw = 9'b0_00_1_0_0_1_0_0;
            6'h04:   ctrl_raw = 9'b0_01_0_1_0_0_0_0;
            6'h08:   ctrl_raw = 9'b0_00_1_0_0_0_1_0;
            default: ctrl_raw = 9'b0;
        endcase
    end

    // load-use hazard against the load in ID/EX; stall is forced low during reset
    always_comb begin
        hazard   = !reset && bus.exMemRead && (bus.exRt != 5'd0) &&
                   (bus.exRt == rs_idx || bus.exRt == rt_idx);
        ctrl_out = (hazard || bus.flush || reset) ? 9'b0 : ctrl_raw;
    end

    assign {bus.RegDest, bus.ALUOp, bus.ALUSrc, bus.Branch,
            bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg} = ctrl_out;

    assign bus.stall     = hazard;
    assign bus.pcWrite   = !hazard;
    assign bus.ifidWrite = !hazard;
    assign bus.pc        = bus.pcIn;
    assign bus.rt        = rt_idx;
    assign bus.rd        = bus.instr[15:11];
    assign bus.offset    = {{16{bus.instr[15]}}, bus.instr[15:0]};
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    localparam logic [8:0] C_NONE = 9'b0_00_0_0_0_0_0_0;
    localparam logic [8:0] C_R    = 9'b1_10_0_0_0_0_1_0;
    localparam logic [8:0] C_LW   = 9'b0_00_1_0_1_0_1_1;
    localparam logic [8:0] C_SW   = 9'b0_00_1_0_0_1_0_0;
    localparam logic [8:0] C_BEQ  = 9'b0_01_0_1_0_0_0_0;
    localparam logic [8:0] C_ADDI = 9'b0_00_1_0_0_0_1_0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] offset;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
        logic        pcw;
        logic        ifw;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];

    decode_stage_if bus ();

    decode_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input string field, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s.%s got=%h exp=%h", tag, field, got, want);
        end
    endtask

    task automatic step(input string tag, input logic rst_i, input logic [31:0] ins,
                        input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd,
                        input logic exm, input logic [4:0] ext, input logic fl,
                        input logic [31:0] e_reg1, input logic [31:0] e_reg2,
                        input logic [8:0] e_ctrl, input logic e_stall);
        exp_t e;
        exp_t g;
        logic [31:0] pcv;
        pcv             = $urandom;
        reset           = rst_i;
        bus.instr       = ins;
        bus.pcIn        = pcv;
        bus.wbRegWrite  = wbe;
        bus.wbWriteReg  = wbr;
        bus.wbWriteData = wbd;
        bus.exMemRead   = exm;
        bus.exRt        = ext;
        bus.flush       = fl;
        e.tag    = tag;
        e.pc     = pcv;
        e.reg1   = e_reg1;
        e.reg2   = e_reg2;
        e.offset = {{16{ins[15]}}, ins[15:0]};
        e.rt     = ins[20:16];
        e.rd     = ins[15:11];
        e.ctrl   = e_ctrl;
        e.pcw    = !e_stall;
        e.ifw    = !e_stall;
        e.stall  = e_stall;
        exp_q.push_back(e);
        @(negedge clock);
        g = exp_q.pop_front();
        chk(g.tag, "pc", bus.pc, g.pc);
        chk(g.tag, "reg1", bus.reg1, g.reg1);
        chk(g.tag, "reg2", bus.reg2, g.reg2);
        chk(g.tag, "offset", bus.offset, g.offset);
        chk(g.tag, "rt", {27'b0, bus.rt}, {27'b0, g.rt});
        chk(g.tag, "rd", {27'b0, bus.rd}, {27'b0, g.rd});
        chk(g.tag, "ctrl", {23'b0, bus.RegDest, bus.ALUOp, bus.ALUSrc, bus.Branch,
                            bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg}, {23'b0, g.ctrl});
        chk(g.tag, "pcWrite", {31'b0, bus.pcWrite}, {31'b0, g.pcw});
        chk(g.tag, "ifidWrite", {31'b0, bus.ifidWrite}, {31'b0, g.ifw});
        chk(g.tag, "stall", {31'b0, bus.stall}, {31'b0, g.stall});
        @(posedge clock);
        #1;
    endtask

    initial begin
        //    tag          rst  instr         wbe wbr   wbd           exm ext   fl   reg1          reg2          ctrl    stall
        step("reset",      1, 32'h00A53020, 0, 5'd0, 32'h0,        1, 5'd5, 0, 32'h0,        32'h0,        C_NONE, 0);
        step("wr_r5",      0, 32'h00000000, 1, 5'd5, 32'h12345678, 0, 5'd0, 0, 32'h0,        32'h0,        C_R,    0);
        step("add_r5",     0, 32'h00A53020, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h12345678, 32'h12345678, C_R,    0);
        step("bypass_r9",  0, 32'h01204820, 1, 5'd9, 32'hDEADBEEF, 0, 5'd0, 0, 32'hDEADBEEF, 32'h0,        C_R,    0);
        step("bypass_r8",  0, 32'h01095020, 1, 5'd8, 32'h00000088, 0, 5'd0, 0, 32'h00000088, 32'hDEADBEEF, C_R,    0);
        step("haz_rs",     0, 32'h01095020, 0, 5'd0, 32'h0,        1, 5'd8, 0, 32'h00000088, 32'hDEADBEEF, C_NONE, 1);
        step("haz_rt",     0, 32'h01095020, 0, 5'd0, 32'h0,        1, 5'd9, 0, 32'h00000088, 32'hDEADBEEF, C_NONE, 1);
        step("haz_miss",   0, 32'h01095020, 0, 5'd0, 32'h0,        1, 5'd7, 0, 32'h00000088, 32'hDEADBEEF, C_R,    0);
        step("no_load",    0, 32'h01095020, 0, 5'd0, 32'h0,        0, 5'd8, 0, 32'h00000088, 32'hDEADBEEF, C_R,    0);
        step("lw_sext",    0, 32'h8C22FFFC, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        C_LW,   0);
        step("sw_flush",   0, 32'hAC22FFFC, 0, 5'd0, 32'h0,        0, 5'd0, 1, 32'h0,        32'h0,        C_NONE, 0);
        step("sw",         0, 32'hAC22FFFC, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        C_SW,   0);
        step("beq",        0, 32'h10A50004, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h12345678, 32'h12345678, C_BEQ,  0);
        step("addi",       0, 32'h20A60010, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h12345678, 32'h0,        C_ADDI, 0);
        step("bad_op",     0, 32'hFC000000, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        C_NONE, 0);
        step("stall_fl",   0, 32'h00A53020, 0, 5'd0, 32'h0,        1, 5'd5, 1, 32'h12345678, 32'h12345678, C_NONE, 1);
        step("wr_r0",      0, 32'h00000000, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 32'h0,        32'h0,        C_R,    0);
        step("rd_r0",      0, 32'h00000000, 0, 5'd0, 32'h0,        1, 5'd0, 0, 32'h0,        32'h0,        C_R,    0);
        step("wr_r3",      0, 32'h00000000, 1, 5'd3, 32'h00000007, 0, 5'd0, 0, 32'h0,        32'h0,        C_R,    0);
        step("rd_r3",      0, 32'h00642020, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h00000007, 32'h0,        C_R,    0);
        step("rst_wb",     1, 32'h00000000, 1, 5'd4, 32'h00000044, 1, 5'd3, 0, 32'h0,        32'h0,        C_NONE, 0);
        step("post_rst",   0, 32'h00642020, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        C_R,    0);
        step("post_rst9",  0, 32'h01095020, 0, 5'd0, 32'h0,        0, 5'd0, 0, 32'h0,        32'h0,        C_R,    0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
